mcpu_core_dcache: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate data cache with one-word lines and a one-entry write buffer.

---
 rtl/mcpu_core_dcache_if.sv | 36 +++
 rtl/mcpu_core_dcache.sv | 231 +++++++++++++++++++++++
 tb/tb_mcpu_core_dcache.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mcpu_core_dcache_if.sv
// Data-cache bus bundle: the mem-stage request side (mem2dc_*) and the
// single-outstanding backing word port toward the memory arbiter (dc2mem_*).
interface mcpu_core_dcache_if;
  // Mem-stage request side
  logic [29:0] mem2dc_paddr;
  logic [3:0]  mem2dc_write;
  logic [31:0] mem2dc_data_out;
  logic        mem2dc_valid;
  logic        mem2dc_done;
  logic [31:0] mem2dc_data_in;

  // Backing port
  logic [29:0] dc2mem_addr;
  logic        dc2mem_valid;
  logic        dc2mem_we;
  logic [3:0]  dc2mem_wmask;
  logic [31:0] dc2mem_wdata;
  logic        dc2mem_ack;
  logic [31:0] dc2mem_rdata;

  // Cache view: responds to mem2dc, initiates dc2mem
  modport slave (
    input  mem2dc_paddr, mem2dc_write, mem2dc_data_out, mem2dc_valid,
    output mem2dc_done, mem2dc_data_in,
    output dc2mem_addr, dc2mem_valid, dc2mem_we, dc2mem_wmask, dc2mem_wdata,
    input  dc2mem_ack, dc2mem_rdata
  );

  // Environment view: mem stage plus memory arbiter
  modport master (
    output mem2dc_paddr, mem2dc_write, mem2dc_data_out, mem2dc_valid,
    input  mem2dc_done, mem2dc_data_in,
    input  dc2mem_addr, dc2mem_valid, dc2mem_we, dc2mem_wmask, dc2mem_wdata,
    output dc2mem_ack, dc2mem_rdata
  );
endinterface

// File: rtl/mcpu_core_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines
// and a one-entry write buffer. The tag/data arrays are read in the accept cycle
// and compared in the following cycle.
module mcpu_core_dcache #(
  parameter int unsigned IDX_BITS = 8
) (
  input  logic              clkrst_core_clk,
  input  logic              clkrst_core_rst_n,
  mcpu_core_dcache_if.slave bus_io
);
  localparam int unsigned TagBits = 30 - IDX_BITS;
  localparam int unsigned Lines   = 1 << IDX_BITS;

  typedef enum logic [1:0] {StRun, StWbWait, StFill, StResp} state_e;

  state_e state_q, state_d;

  // Captured request
  logic        req_v_q, req_v_d;
  logic [29:0] req_addr_q, req_addr_d;
  logic [3:0]  req_mask_q, req_mask_d;
  logic [31:0] req_data_q, req_data_d;

  // One-entry write buffer
  logic        wbuf_v_q, wbuf_v_d;
  logic [29:0] wbuf_addr_q, wbuf_addr_d;
  logic [3:0]  wbuf_mask_q, wbuf_mask_d;
  logic [31:0] wbuf_data_q, wbuf_data_d;

  logic [31:0] fill_q, fill_d;

  // Array read result captured at accept
  logic               rd_valid_q, rd_valid_d;
  logic [TagBits-1:0] rd_tag_q, rd_tag_d;
  logic [31:0]        rd_data_q, rd_data_d;

  logic [Lines-1:0]   valid_q, valid_d;
  logic [TagBits-1:0] tag_mem  [Lines];
  logic [31:0]        data_mem [Lines];

  // Array write port
  logic               arr_we;
  logic [IDX_BITS-1:0] arr_idx;
  logic [TagBits-1:0] arr_tag;
  logic [31:0]        arr_data;

  logic [IDX_BITS-1:0] req_idx, acc_idx;
  logic [TagBits-1:0]  req_tag;
  logic                hit, accept, drain_en, drain_ack, done;
  logic [31:0]         data_in;
  logic                dc_valid, dc_we;
  logic [29:0]         dc_addr;
  logic [3:0]          dc_wmask;
  logic [31:0]         dc_wdata;

  assign req_idx = req_addr_q[IDX_BITS-1:0];
  assign req_tag = req_addr_q[29:IDX_BITS];
  assign acc_idx = bus_io.mem2dc_paddr[IDX_BITS-1:0];
  assign hit     = rd_valid_q && (rd_tag_q == req_tag);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  // Next-state, backing-port and response logic
  always_comb begin
    state_d     = state_q;
    req_v_d     = req_v_q;
    req_addr_d  = req_addr_q;
    req_mask_d  = req_mask_q;
    req_data_d  = req_data_q;
    wbuf_v_d    = wbuf_v_q;
    wbuf_addr_d = wbuf_addr_q;
    wbuf_mask_d = wbuf_mask_q;
    wbuf_data_d = wbuf_data_q;
    fill_d      = fill_q;
    valid_d     = valid_q;
    arr_we      = 1'b0;
    arr_idx     = req_idx;
    arr_tag     = req_tag;
    arr_data    = fill_q;
    done        = 1'b0;
    data_in     = fill_q;
    dc_valid    = 1'b0;
    dc_we       = 1'b0;
    dc_addr     = req_addr_q;
    dc_wmask    = wbuf_mask_q;
    dc_wdata    = wbuf_data_q;

    // Drain only while no fill can be in flight; it stays up through WB_WAIT.
    drain_en  = wbuf_v_q && ((state_q == StRun) || (state_q == StWbWait));
    drain_ack = drain_en && bus_io.dc2mem_ack;
    if (drain_en) begin
      dc_valid = 1'b1;
      dc_we    = 1'b1;
      dc_addr  = wbuf_addr_q;
    end
    if (drain_ack) wbuf_v_d = 1'b0;

    unique case (state_q)
      StRun: begin
        if (!req_v_q) begin
          done = 1'b1;
        end else if (req_mask_q == 4'd0) begin
          if (hit) begin
            done    = 1'b1;
            data_in = rd_data_q;
          end else begin
            // A buffered write must reach memory before the fill reads it.
            state_d = (wbuf_v_q && !drain_ack) ? StWbWait : StFill;
          end
        end else if (!wbuf_v_q || drain_ack) begin
          done        = 1'b1;
          wbuf_v_d    = 1'b1;
          wbuf_addr_d = req_addr_q;
          wbuf_mask_d = req_mask_q;
          wbuf_data_d = req_data_q;
          if (hit) begin
            arr_we   = 1'b1;
            arr_data = merge_bytes(rd_data_q, req_data_q, req_mask_q);
          end
        end
      end
      StWbWait: begin
        if (drain_ack) state_d = StFill;
      end
      StFill: begin
        dc_valid = 1'b1;
        dc_we    = 1'b0;
        dc_addr  = req_addr_q;
        dc_wmask = 4'd0;
        if (bus_io.dc2mem_ack) begin
          arr_we           = 1'b1;
          arr_data         = bus_io.dc2mem_rdata;
          valid_d[req_idx] = 1'b1;
          fill_d           = bus_io.dc2mem_rdata;
          state_d          = StResp;
        end
      end
      StResp: begin
        done    = 1'b1;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    accept = done && bus_io.mem2dc_valid;
    if (done) begin
      req_v_d = accept;
      if (accept) begin
        req_addr_d = bus_io.mem2dc_paddr;
        req_mask_d = bus_io.mem2dc_write;
        req_data_d = bus_io.mem2dc_data_out;
      end
    end
  end

  // Array lookup at accept, forwarding a same-cycle array write to the same line
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_tag_d   = rd_tag_q;
    rd_data_d  = rd_data_q;
    if (accept) begin
      rd_valid_d = valid_q[acc_idx];
      rd_tag_d   = tag_mem[acc_idx];
      rd_data_d  = data_mem[acc_idx];
      if (arr_we && (arr_idx == acc_idx)) begin
        rd_valid_d = 1'b1;
        rd_tag_d   = arr_tag;
        rd_data_d  = arr_data;
      end
    end
  end

  // Control and datapath registers with synchronous reset
  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      state_q     <= StRun;
      req_v_q     <= 1'b0;
      req_addr_q  <= '0;
      req_mask_q  <= '0;
      req_data_q  <= '0;
      wbuf_v_q    <= 1'b0;
      wbuf_addr_q <= '0;
      wbuf_mask_q <= '0;
      wbuf_data_q <= '0;
      fill_q      <= '0;
      valid_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_tag_q    <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_v_q     <= req_v_d;
      req_addr_q  <= req_addr_d;
      req_mask_q  <= req_mask_d;
      req_data_q  <= req_data_d;
      wbuf_v_q    <= wbuf_v_d;
      wbuf_addr_q <= wbuf_addr_d;
      wbuf_mask_q <= wbuf_mask_d;
      wbuf_data_q <= wbuf_data_d;
      fill_q      <= fill_d;
      valid_q     <= valid_d;
      rd_valid_q  <= rd_valid_d;
      rd_tag_q    <= rd_tag_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Tag/data arrays; contents are qualified by valid_q so they need no reset
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst_n && arr_we) begin
      tag_mem[arr_idx]  <= arr_tag;
      data_mem[arr_idx] <= arr_data;
    end
  end

  assign bus_io.mem2dc_done    = done;
  assign bus_io.mem2dc_data_in = data_in;
  assign bus_io.dc2mem_addr    = dc_addr;
  assign bus_io.dc2mem_valid   = dc_valid;
  assign bus_io.dc2mem_we      = dc_we;
  assign bus_io.dc2mem_wmask   = dc_wmask;
  assign bus_io.dc2mem_wdata   = dc_wdata;
endmodule

// File: tb/tb_mcpu_core_dcache.sv
// Directed bench for mcpu_core_dcache. Inputs change just after the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_mcpu_core_dcache;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  mcpu_core_dcache_if bus ();

  mcpu_core_dcache #(.IDX_BITS(8)) dut (
    .clkrst_core_clk  (clk),
    .clkrst_core_rst_n(rst_n),
    .bus_io           (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d);
    bus.mem2dc_valid    = 1'b1;
    bus.mem2dc_paddr    = a;
    bus.mem2dc_write    = m;
    bus.mem2dc_data_out = d;
  endtask

  task automatic idle();
    bus.mem2dc_valid = 1'b0;
  endtask

  // Read expected to miss: waits (bounded) for the fill, holds ack off for dly
  // extra cycles, then returns data mdata and checks the RESP cycle.
  task automatic read_miss(input logic [29:0] a, input logic [31:0] mdata, input int dly,
                           input string tag);
    bit seen;
    @(negedge clk); req(a, 4'h0, 32'h0); #1;
    chk($sformatf("%s_acc", tag), 32'(bus.mem2dc_done), 32'd1);
    @(negedge clk); idle(); #1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.dc2mem_valid && !bus.dc2mem_we) begin
        seen = 1'b1;
      end else begin
        chk($sformatf("%s_miss_done", tag), 32'(bus.mem2dc_done), 32'd0);
        @(negedge clk); #1;
      end
    end
    chk($sformatf("%s_fill_seen", tag), 32'(seen), 32'd1);
    chk($sformatf("%s_fill_addr", tag), 32'(bus.dc2mem_addr), 32'(a));
    for (int i = 0; i < dly; i++) begin
      chk($sformatf("%s_fill_done", tag), 32'(bus.mem2dc_done), 32'd0);
      @(negedge clk); #1;
      chk($sformatf("%s_fill_held", tag), 32'(bus.dc2mem_valid), 32'd1);
    end
    bus.dc2mem_ack = 1'b1; bus.dc2mem_rdata = mdata;
    @(negedge clk); bus.dc2mem_ack = 1'b0; bus.dc2mem_rdata = 32'h0; #1;
    chk($sformatf("%s_resp_done", tag), 32'(bus.mem2dc_done), 32'd1);
    chk($sformatf("%s_resp_data", tag), bus.mem2dc_data_in, mdata);
    chk($sformatf("%s_resp_dcv", tag), 32'(bus.dc2mem_valid), 32'd0);
  endtask

  task automatic read_hit(input logic [29:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk); req(a, 4'h0, 32'h0); #1;
    chk($sformatf("%s_acc", tag), 32'(bus.mem2dc_done), 32'd1);
    @(negedge clk); idle(); #1;
    chk($sformatf("%s_done", tag), 32'(bus.mem2dc_done), 32'd1);
    chk($sformatf("%s_data", tag), bus.mem2dc_data_in, exp);
    chk($sformatf("%s_dcv", tag), 32'(bus.dc2mem_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a request presented that must be ignored
    rst_n = 1'b0;
    bus.dc2mem_ack = 1'b0; bus.dc2mem_rdata = 32'h0;
    req(30'h10, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_done", 32'(bus.mem2dc_done), 32'd1);
    chk("rst_dcv", 32'(bus.dc2mem_valid), 32'd0);
    chk("rst_data", bus.mem2dc_data_in, 32'h0);
    rst_n = 1'b1; idle();
    @(negedge clk); #1;
    chk("rst_req_ignored_dcv", 32'(bus.dc2mem_valid), 32'd0);
    chk("rst_req_ignored_done", 32'(bus.mem2dc_done), 32'd1);

    // T1: cold miss with delayed ack, then 1-cycle hit
    read_miss(30'h10, 32'hDEADBEEF, 2, "t1");
    read_hit(30'h10, 32'hDEADBEEF, "t1_reread");

    // T2: write hit merges byte 1; drain fields; drain ack coincides with a new accept
    @(negedge clk); req(30'h10, 4'b0010, 32'h0000AA00); #1;
    chk("t2_wr_acc", 32'(bus.mem2dc_done), 32'd1);
    @(negedge clk); idle(); #1;
    chk("t2_wr_done", 32'(bus.mem2dc_done), 32'd1);
    chk("t2_no_drain_yet", 32'(bus.dc2mem_valid), 32'd0);
    @(negedge clk); req(30'h10, 4'h0, 32'h0); #1;
    chk("t2_drain_v", 32'(bus.dc2mem_valid), 32'd1);
    chk("t2_drain_we", 32'(bus.dc2mem_we), 32'd1);
    chk("t2_drain_addr", 32'(bus.dc2mem_addr), 32'h10);
    chk("t2_drain_mask", 32'(bus.dc2mem_wmask), 32'h2);
    chk("t2_drain_wdata", bus.dc2mem_wdata, 32'h0000AA00);
    chk("t2_rd_acc", 32'(bus.mem2dc_done), 32'd1);
    bus.dc2mem_ack = 1'b1;
    @(negedge clk); bus.dc2mem_ack = 1'b0; idle(); #1;
    chk("t2_hit_done", 32'(bus.mem2dc_done), 32'd1);
    chk("t2_hit_data", bus.mem2dc_data_in, 32'hDEADAAEF);
    chk("t2_drained", 32'(bus.dc2mem_valid), 32'd0);

    // T3: write miss then read of the same line: drain first, then fill
    @(negedge clk); req(30'h20, 4'hF, 32'h12345678); #1;
    chk("t3_wr_acc", 32'(bus.mem2dc_done), 32'd1);
    @(negedge clk); req(30'h20, 4'h0, 32'h0); #1;
    chk("t3_wr_done", 32'(bus.mem2dc_done), 32'd1);
    @(negedge clk); idle(); #1;
    chk("t3_rd_miss", 32'(bus.mem2dc_done), 32'd0);
    chk("t3_drain_first_we", 32'(bus.dc2mem_we), 32'd1);
    chk("t3_drain_first_addr", 32'(bus.dc2mem_addr), 32'h20);
    @(negedge clk); #1;
    chk("t3_wbwait_done", 32'(bus.mem2dc_done), 32'd0);
    chk("t3_wbwait_we", 32'(bus.dc2mem_we), 32'd1);
    bus.dc2mem_ack = 1'b1;
    @(negedge clk); bus.dc2mem_ack = 1'b0; #1;
    chk("t3_fill_v", 32'(bus.dc2mem_valid), 32'd1);
    chk("t3_fill_we", 32'(bus.dc2mem_we), 32'd0);
    chk("t3_fill_addr", 32'(bus.dc2mem_addr), 32'h20);
    bus.dc2mem_ack = 1'b1; bus.dc2mem_rdata = 32'h12345678;
    @(negedge clk); bus.dc2mem_ack = 1'b0; #1;
    chk("t3_resp_done", 32'(bus.mem2dc_done), 32'd1);
    chk("t3_resp_data", bus.mem2dc_data_in, 32'h12345678);

    // T4: back-to-back writes, drain ack held off
    @(negedge clk); req(30'h30, 4'hF, 32'h11111111); #1;
    chk("t4_w1_acc", 32'(bus.mem2dc_done), 32'd1);
    @(negedge clk); req(30'h31, 4'hF, 32'h22222222); #1;
    chk("t4_w1_done", 32'(bus.mem2dc_done), 32'd1);
    @(negedge clk); idle(); #1;
    chk("t4_w2_stall", 32'(bus.mem2dc_done), 32'd0);
    chk("t4_drain1_addr", 32'(bus.dc2mem_addr), 32'h30);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t4_w2_held", 32'(bus.mem2dc_done), 32'd0);
      chk("t4_drain1_held", 32'(bus.dc2mem_addr), 32'h30);
    end
    @(negedge clk); bus.dc2mem_ack = 1'b1; #1;
    chk("t4_ack_cycle_done", 32'(bus.mem2dc_done), 32'd1);
    @(negedge clk); bus.dc2mem_ack = 1'b0; #1;
    chk("t4_drain2_addr", 32'(bus.dc2mem_addr), 32'h31);
    chk("t4_drain2_wdata", bus.dc2mem_wdata, 32'h22222222);
    chk("t4_idle_done", 32'(bus.mem2dc_done), 32'd1);
    bus.dc2mem_ack = 1'b1;
    @(negedge clk); bus.dc2mem_ack = 1'b0; #1;
    chk("t4_empty", 32'(bus.dc2mem_valid), 32'd0);

    // T5: aliasing lines 0x005 and 0x105 evict each other
    read_miss(30'h005, 32'hA5A5A5A5, 0, "t5_a");
    read_miss(30'h105, 32'hB0B0B0B0, 0, "t5_b");
    read_hit(30'h105, 32'hB0B0B0B0, "t5_b_hit");
    read_miss(30'h005, 32'hA5A5A5C3, 1, "t5_a_again");

    // T6: reset during a fill; the late ack is ignored and lines are invalid
    @(negedge clk); req(30'h40, 4'h0, 32'h0); #1;
    @(negedge clk); idle(); #1;
    @(negedge clk); #1;
    chk("t6_fill_v", 32'(bus.dc2mem_valid), 32'd1);
    chk("t6_fill_we", 32'(bus.dc2mem_we), 32'd0);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("t6_rst_dcv", 32'(bus.dc2mem_valid), 32'd0);
    chk("t6_rst_done", 32'(bus.mem2dc_done), 32'd1);
    chk("t6_rst_data", bus.mem2dc_data_in, 32'h0);
    @(negedge clk); bus.dc2mem_ack = 1'b1; bus.dc2mem_rdata = 32'hBAD0BAD0; #1;
    chk("t6_late_ack_done", 32'(bus.mem2dc_done), 32'd1);
    @(negedge clk); bus.dc2mem_ack = 1'b0; bus.dc2mem_rdata = 32'h0; #1;
    chk("t6_after_ack_dcv", 32'(bus.dc2mem_valid), 32'd0);
    chk("t6_after_ack_data", bus.mem2dc_data_in, 32'h0);
    read_miss(30'h10, 32'hDEADAAEF, 0, "t6_reread");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
